// File: rtl/mux_lut_gate_array.sv
// WIDTH-lane programmable 2-input logic unit: each lane is a 4:1 mux over a
// run-time loadable truth table, with a one-stage valid/ready output register.
module mux_lut_gate_array #(
  parameter int WIDTH = 8,
  parameter int NSLOT = 4,
  parameter int SW    = $clog2(NSLOT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SW-1:0]    in_slot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  input  logic             cfg_start,
  input  logic [SW-1:0]    cfg_slot,
  input  logic             cfg_bit,
  output logic             cfg_busy,
  output logic             cfg_done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam logic [SW:0] NSLOT_W = (SW+1)'(NSLOT);

  // Power-up contents: XOR, XNOR, AND, OR; any further slots start empty.
  function automatic logic [3:0] tt_reset_val(input int idx);
    logic [3:0] val;
    case (idx)
      0:       val = 4'b0110;
      1:       val = 4'b1001;
      2:       val = 4'b1000;
      3:       val = 4'b1110;
      default: val = 4'b0000;
    endcase
    return val;
  endfunction

  // Two-level mux tree: b picks within each half, a picks the half.
  function automatic logic lane_mux(input logic [3:0] tt, input logic a, input logic b);
    logic lo;
    logic hi;
    lo = b ? tt[1] : tt[0];
    hi = b ? tt[3] : tt[2];
    return a ? hi : lo;
  endfunction

  state_e           state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [3:0]       shadow_q, shadow_d;
  logic             done_q, done_d;
  logic             commit_s;
  logic [3:0]       tt_q [NSLOT];
  logic [3:0]       tt_d [NSLOT];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [3:0]       sel_tt_s;
  logic [WIDTH-1:0] lane_y_s;
  logic             in_ready_s;
  logic             accept_s;

  // Config FSM next-state: the start cycle only latches the slot, then four data bits.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d  = ST_LOAD;
          slot_d   = cfg_slot;
          cnt_d    = 2'd0;
          shadow_d = 4'b0000;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        shadow_d = {shadow_q[2:0], cfg_bit};
        if (cnt_q == 2'd3) begin
          commit_s = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = 2'd0;
        end else begin
          cnt_d    = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Config FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      cnt_q    <= 2'd0;
      shadow_q <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  // Atomic table write; an out-of-range target slot matches nothing and is dropped.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      if (commit_s && ({1'b0, slot_q} == (SW+1)'(s))) begin
        tt_d[s] = shadow_d;
      end else begin
        tt_d[s] = tt_q[s];
      end
    end
  end

  // Truth-table storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSLOT; s++) begin
        tt_q[s] <= tt_reset_val(s);
      end
    end else begin
      for (int s = 0; s < NSLOT; s++) begin
        tt_q[s] <= tt_d[s];
      end
    end
  end

  // Slot select and per-lane evaluation; unknown slots yield an all-zero result.
  always_comb begin
    sel_tt_s = 4'b0000;
    if ({1'b0, in_slot} < NSLOT_W) begin
      sel_tt_s = tt_q[in_slot];
    end else begin
      sel_tt_s = 4'b0000;
    end
    for (int i = 0; i < WIDTH; i++) begin
      lane_y_s[i] = lane_mux(sel_tt_s, in_a[i], in_b[i]);
    end
  end

  assign in_ready_s = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept_s   = in_valid && in_ready_s;

  // Output stage: load on accept, clear valid on drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_y_d     = lane_y_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_y_d     = out_y_q;
    end else begin
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
    end
  end

  // Output pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign cfg_busy  = (state_q == ST_LOAD);
  assign cfg_done  = done_q;

endmodule

// File: tb/tb_mux_lut_gate_array.sv
// Scoreboard bench for mux_lut_gate_array: expected results are queued on accept
// and compared when the output register drains.
module tb_mux_lut_gate_array;

  localparam int WIDTH = 8;
  localparam int NSLOT = 4;
  localparam int SW    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_a, in_b, out_y;
  logic [SW-1:0]    in_slot, cfg_slot;
  logic             cfg_start, cfg_bit, cfg_busy, cfg_done;

  int               n_tests = 0;
  int               n_fail  = 0;
  int               cyc     = 0;
  logic [3:0]       m_tt [NSLOT];
  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] mon_exp;
  logic [WIDTH-1:0] t1_exp [4];
  logic [WIDTH-1:0] held;
  int               t_start;

  mux_lut_gate_array #(.WIDTH(WIDTH), .NSLOT(NSLOT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_slot(in_slot),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .cfg_start(cfg_start), .cfg_slot(cfg_slot), .cfg_bit(cfg_bit),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_y(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [3:0] tt);
    logic [WIDTH-1:0] y;
    for (int i = 0; i < WIDTH; i++) y[i] = tt[{a[i], b[i]}];
    return y;
  endfunction

  task automatic model_reset();
    m_tt[0] = 4'b0110;
    m_tt[1] = 4'b1001;
    m_tt[2] = 4'b1000;
    m_tt[3] = 4'b1110;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_extra_result", 32'(sb_q.size()), 32'd1);
        end else begin
          mon_exp = sb_q.pop_front();
          check_eq("sb_y", 32'(out_y), 32'(mon_exp));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model_y(in_a, in_b, m_tt[in_slot]));
      if (cfg_busy) check_eq("in_ready_during_load", 32'(in_ready), 32'd0);
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [SW-1:0] s);
    bit ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_slot = s; in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("send_accepted", 32'(ok), 32'd1);
    @(posedge clk); #1;
    if (!ok) in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cfg_load(input logic [SW-1:0] slot, input logic [3:0] bits);
    cfg_start = 1'b1; cfg_slot = slot;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_slot = ~slot;
    check_eq("cfg_busy_start", 32'(cfg_busy), 32'd1);
    for (int k = 3; k >= 0; k--) begin
      cfg_bit = bits[k];
      cfg_start = (k == 2);
      if (k == 0) m_tt[slot] = bits;
      check_eq("cfg_done_early", 32'(cfg_done), 32'd0);
      @(posedge clk); #1;
    end
    cfg_start = 1'b0;
    check_eq("cfg_done_pulse", 32'(cfg_done), 32'd1);
    check_eq("cfg_busy_end", 32'(cfg_busy), 32'd0);
    @(posedge clk); #1;
    check_eq("cfg_done_width", 32'(cfg_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0; in_slot = '0;
    cfg_start = 1'b0; cfg_slot = '0; cfg_bit = 1'b0;
    t1_exp[0] = 8'h3C; t1_exp[1] = 8'hC3; t1_exp[2] = 8'hC0; t1_exp[3] = 8'hFC;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_y", 32'(out_y), 32'd0);
    check_eq("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    check_eq("rst_cfg_done", 32'(cfg_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 1: reset tables on a fixed pattern
    for (int s = 0; s < 4; s++) begin
      send(8'hF0, 8'hCC, SW'(s));
      in_valid = 1'b0;
      @(negedge clk);
      check_eq($sformatf("t1_slot%0d", s), 32'(out_y), 32'(t1_exp[s]));
      @(posedge clk); #1;
    end

    // 2: load NAND into slot 2
    cfg_load(2'd2, 4'b0111);
    send(8'hF0, 8'hCC, 2'd2);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_nand", 32'(out_y), 32'h3F);
    @(posedge clk); #1;

    // 3: output stall with pending input
    out_ready = 1'b0;
    send(8'hA5, 8'h3C, 2'd0);
    held = model_y(8'hA5, 8'h3C, m_tt[0]);
    in_a = 8'h5A; in_b = 8'hC3; in_slot = 2'd1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t3_stall_ready", 32'(in_ready), 32'd0);
      check_eq("t3_stall_valid", 32'(out_valid), 32'd1);
      check_eq("t3_stall_y", 32'(out_y), 32'(held));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'h5A, 8'hC3, 2'd1);
    send(8'hFF, 8'h00, 2'd2);
    send(8'h00, 8'hFF, 2'd3);
    drain();
    check_eq("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // 4: streaming, one result per clock
    t_start = cyc;
    for (int k = 0; k < 16; k++) begin
      send(WIDTH'($urandom), WIDTH'($urandom), SW'($urandom_range(0, NSLOT-1)));
    end
    check_eq("t4_throughput", 32'(cyc - t_start), 32'd16);
    drain();
    check_eq("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // 5: load while a result is stalled; slot 3 becomes NOR
    out_ready = 1'b0;
    send(8'hC3, 8'h5A, 2'd3);
    in_valid = 1'b0;
    fork
      cfg_load(2'd3, 4'b0001);
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'hF0, 8'hCC, 2'd3);
        in_valid = 1'b0;
      end
    join
    @(negedge clk);
    check_eq("t5_new_table", 32'(out_y), 32'h03);
    check_eq("t5_valid", 32'(out_valid), 32'd1);
    drain();
    check_eq("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // 6: reset in the middle of a load restores power-up tables
    cfg_load(2'd0, 4'b1000);
    out_ready = 1'b0;
    send(8'h0F, 8'h00, 2'd0);
    in_valid = 1'b0;
    cfg_start = 1'b1; cfg_slot = 2'd0;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_bit = 1'b1;
    @(posedge clk); #1;
    cfg_bit = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_busy_at_reset", 32'(cfg_busy), 32'd0);
    check_eq("t6_valid_at_reset", 32'(out_valid), 32'd0);
    sb_q.delete();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfg_bit = 1'b0;
    out_ready = 1'b1;
    send(8'h0F, 8'h00, 2'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_slot0_xor", 32'(out_y), 32'h0F);
    drain();
    check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
